// File: rtl/dm_pkg.sv
// Shared constants for the data-memory access unit: memory size, size encodings, FSM states
// and the request alignment check.
package dm_pkg;

   localparam int unsigned DATA_MEM_SIZE = 128;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   // High for an illegal size or an address not aligned to the access size.
   function automatic logic size_addr_err(input logic [1:0] size, input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      case (size)
         SZ_BYTE: err = 1'b0;
         SZ_HALF: err = addr_lo[0];
         SZ_WORD: err = (addr_lo != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational byte-lane logic: big-endian store merge for read-modify-write and load
// extraction with sign/zero extension.
module dm_lane_merge
   import dm_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] rd_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] st_word_o,
   output logic [31:0] ld_data_o
);

   logic sign_b;
   logic sign_h;

   assign sign_b = ~unsigned_i & rd_i[31];
   assign sign_h = ~unsigned_i & rd_i[31];

   // The addressed byte sits in the most significant lane of the read word.
   always_comb begin
      st_word_o = wdata_i;
      ld_data_o = rd_i;
      case (size_i)
         SZ_BYTE: begin
            st_word_o = {wdata_i[7:0], rd_i[23:0]};
            ld_data_o = {{24{sign_b}}, rd_i[31:24]};
         end
         SZ_HALF: begin
            st_word_o = {wdata_i[15:0], rd_i[15:0]};
            ld_data_o = {{16{sign_h}}, rd_i[31:16]};
         end
         default: begin
            st_word_o = wdata_i;
            ld_data_o = rd_i;
         end
      endcase
   end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores, sub-word stores as read-modify-write.
// Optional DM_ACCESS_BOUNDS_EN flags addresses >= MEM_SIZE as errors instead of aliasing them.
module dm_access_unit
   import dm_pkg::*;
#(
   parameter int unsigned MEM_SIZE = DATA_MEM_SIZE
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_w_data_o,
   output logic        mem_w_o,
   output logic        mem_r_o,
   input  logic [31:0] mem_r_data_i
);

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] wword_q, wword_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic        err_q, err_d;

   logic        req_err;
   logic        oob;
   logic [31:0] st_word;
   logic [31:0] ld_data;

`ifdef DM_ACCESS_BOUNDS_EN
   assign oob = (req_addr_i >= 32'(MEM_SIZE));
`else
   assign oob = 1'b0;
`endif

   assign req_err = size_addr_err(req_size_i, req_addr_i[1:0]) | oob;

   dm_lane_merge u_lane_merge (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .rd_i       (mem_r_data_i),
      .wdata_i    (wdata_q),
      .st_word_o  (st_word),
      .ld_data_o  (ld_data)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wword_d = wword_q;
      rdata_d = rdata_q;
      size_d  = size_q;
      we_d    = we_q;
      uns_d   = uns_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               size_d  = req_size_i;
               we_d    = req_we_i;
               uns_d   = req_unsigned_i;
               err_d   = req_err;
               rdata_d = 32'h0;
               if (req_err) begin
                  state_d = RESP;
               end else if (!req_we_i || (req_size_i != SZ_WORD)) begin
                  state_d = READ;
               end else begin
                  wword_d = req_wdata_i;
                  state_d = WRITE;
               end
            end
         end
         READ: begin
            // Memory read is combinational; capture at the edge that ends this cycle.
            if (we_q) begin
               wword_d = st_word;
               state_d = WRITE;
            end else begin
               rdata_d = ld_data;
               state_d = RESP;
            end
         end
         WRITE: begin
            state_d = RESP;
         end
         RESP: begin
            rdata_d = 32'h0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wword_q <= 32'h0;
         rdata_q <= 32'h0;
         size_q  <= SZ_BYTE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wword_q <= wword_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP);
   assign resp_err_o   = (state_q == RESP) & err_q;
   assign resp_rdata_o = rdata_q;
   assign mem_addr_o   = addr_q;
   assign mem_w_data_o = wword_q;
   assign mem_r_o      = (state_q == READ);
   assign mem_w_o      = (state_q == WRITE);

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit paired with a big-endian 128-byte data memory model.
// Honours DM_ACCESS_BOUNDS_EN for the out-of-range load case.
module tb_dm_access_unit;
   import dm_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_w_data_o;
   logic        mem_w_o;
   logic        mem_r_o;
   logic [31:0] mem_r_data_i;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned n_wcyc   = 0;

   logic [7:0] mem [128];
   logic [6:0] a0, a1, a2, a3;

   always #5 clk_i = ~clk_i;

   dm_access_unit #(.MEM_SIZE(DATA_MEM_SIZE)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .resp_valid_o   (resp_valid_o),
      .resp_rdata_o   (resp_rdata_o),
      .resp_err_o     (resp_err_o),
      .mem_addr_o     (mem_addr_o),
      .mem_w_data_o   (mem_w_data_o),
      .mem_w_o        (mem_w_o),
      .mem_r_o        (mem_r_o),
      .mem_r_data_i   (mem_r_data_i)
   );

   assign a0 = mem_addr_o[6:0];
   assign a1 = a0 + 7'd1;
   assign a2 = a0 + 7'd2;
   assign a3 = a0 + 7'd3;
   assign mem_r_data_i = {mem[a0], mem[a1], mem[a2], mem[a3]};

   // Memory model: byte i starts as (i*7+3) & 0xFF; whole-word writes commit on the falling edge.
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'((i * 7 + 3) & 255);
      forever begin
         @(negedge clk_i);
         if (mem_w_o) begin
            mem[a0] = mem_w_data_o[31:24];
            mem[a1] = mem_w_data_o[23:16];
            mem[a2] = mem_w_data_o[15:8];
            mem[a3] = mem_w_data_o[7:0];
            n_wcyc++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request and records latency plus per-cycle Mem_r/Mem_w activity (bit i = cycle i).
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic err, output logic [31:0] rd,
                         output logic [7:0] tr, output logic [7:0] tw);
      @(negedge clk_i);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      lat = 0;
      err = 1'b0;
      rd  = 32'h0;
      tr  = 8'h0;
      tw  = 8'h0;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk_i);
         tr[i] = mem_r_o;
         tw[i] = mem_w_o;
         if (resp_valid_o) begin
            lat = i;
            err = resp_err_o;
            rd  = resp_rdata_o;
            break;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   int          lat;
   logic        err;
   logic [31:0] rd;
   logic [7:0]  tr, tw;
   int unsigned w0;

   initial begin
      rst_ni         = 1'b0;
      req_valid_i    = 1'b0;
      req_we_i       = 1'b0;
      req_size_i     = SZ_BYTE;
      req_unsigned_i = 1'b0;
      req_addr_i     = 32'h0;
      req_wdata_i    = 32'h0;
      #12;
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      check("rst_resp_err", 32'(resp_err_o), 32'd0);
      check("rst_rdata", resp_rdata_o, 32'h0);
      check("rst_mem_w", 32'(mem_w_o), 32'd0);
      check("rst_mem_r", 32'(mem_r_o), 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'h0);
      check("rst_mem_wdata", mem_w_data_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1: word store then word load
      w0 = n_wcyc;
      do_req(1'b1, SZ_WORD, 1'b0, 32'd8, 32'h11223344, lat, err, rd, tr, tw);
      check("t1_st_lat", 32'(lat), 32'd2);
      check("t1_st_err", 32'(err), 32'd0);
      check("t1_st_rdata", rd, 32'h0);
      check("t1_st_trace_w", 32'(tw), 32'h02);
      check("t1_st_trace_r", 32'(tr), 32'h00);
      do_req(1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, lat, err, rd, tr, tw);
      check("t1_ld_lat", 32'(lat), 32'd2);
      check("t1_ld_rdata", rd, 32'h11223344);
      check("t1_ld_trace_r", 32'(tr), 32'h02);
      check("t1_wcyc", n_wcyc - w0, 32'd1);

      // 2: byte store is a read-modify-write
      do_req(1'b1, SZ_BYTE, 1'b0, 32'd9, 32'h000000AB, lat, err, rd, tr, tw);
      check("t2_st_lat", 32'(lat), 32'd3);
      check("t2_trace_r", 32'(tr), 32'h02);
      check("t2_trace_w", 32'(tw), 32'h04);
      do_req(1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, lat, err, rd, tr, tw);
      check("t2_ld_rdata", rd, 32'h11AB3344);

      // 3: extension; bytes 9..11 become 0x80, 0xFF, 0x12
      do_req(1'b1, SZ_WORD, 1'b0, 32'd8, 32'h0080FF12, lat, err, rd, tr, tw);
      do_req(1'b0, SZ_BYTE, 1'b0, 32'd9, 32'h0, lat, err, rd, tr, tw);
      check("t3_lb_signed", rd, 32'hFFFFFF80);
      do_req(1'b0, SZ_BYTE, 1'b1, 32'd9, 32'h0, lat, err, rd, tr, tw);
      check("t3_lb_unsigned", rd, 32'h00000080);
      do_req(1'b0, SZ_HALF, 1'b0, 32'd9, 32'h0, lat, err, rd, tr, tw);
      check("t3_lh9_err", 32'(err), 32'd1);
      check("t3_lh9_lat", 32'(lat), 32'd1);
      check("t3_lh9_no_r", 32'(tr), 32'h00);
      check("t3_lh9_rdata", rd, 32'h0);
      do_req(1'b0, SZ_HALF, 1'b0, 32'd10, 32'h0, lat, err, rd, tr, tw);
      check("t3_lh10_signed", rd, 32'hFFFFFF12);
      check("t3_lh10_err", 32'(err), 32'd0);
      do_req(1'b0, SZ_HALF, 1'b1, 32'd10, 32'h0, lat, err, rd, tr, tw);
      check("t3_lh10_unsigned", rd, 32'h0000FF12);

      // 4: misaligned word store and illegal size
      w0 = n_wcyc;
      do_req(1'b1, SZ_WORD, 1'b0, 32'd6, 32'hDEADBEEF, lat, err, rd, tr, tw);
      check("t4_mis_err", 32'(err), 32'd1);
      check("t4_mis_lat", 32'(lat), 32'd1);
      check("t4_mis_bus", 32'({tr, tw}), 32'h0);
      do_req(1'b1, SZ_ILL, 1'b0, 32'd4, 32'hDEADBEEF, lat, err, rd, tr, tw);
      check("t4_ill_err", 32'(err), 32'd1);
      check("t4_ill_lat", 32'(lat), 32'd1);
      check("t4_ill_bus", 32'({tr, tw}), 32'h0);
      check("t4_wcyc", n_wcyc - w0, 32'd0);
      do_req(1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, lat, err, rd, tr, tw);
      check("t4_mem4", rd, 32'h1F262D34);

      // 5: reset during the WRITE cycle of a half store
      w0 = n_wcyc;
      @(negedge clk_i);
      req_valid_i    = 1'b1;
      req_we_i       = 1'b1;
      req_size_i     = SZ_HALF;
      req_unsigned_i = 1'b0;
      req_addr_i     = 32'd20;
      req_wdata_i    = 32'h0000BEEF;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("t5_in_write", 32'(mem_w_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("t5_mem_w_drop", 32'(mem_w_o), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         check("t5_no_resp", 32'(resp_valid_o), 32'd0);
      end
      rst_ni = 1'b1;
      #1;
      check("t5_ready", 32'(req_ready_o), 32'd1);
      check("t5_wcyc", n_wcyc - w0, 32'd0);
      do_req(1'b0, SZ_WORD, 1'b0, 32'd20, 32'h0, lat, err, rd, tr, tw);
      check("t5_mem20", rd, 32'h8F969DA4);

      // 6: address beyond the memory
      do_req(1'b0, SZ_WORD, 1'b0, 32'd200, 32'h0, lat, err, rd, tr, tw);
`ifdef DM_ACCESS_BOUNDS_EN
      check("t6_oob_err", 32'(err), 32'd1);
      check("t6_oob_lat", 32'(lat), 32'd1);
      check("t6_oob_no_r", 32'(tr), 32'h00);
`else
      check("t6_alias_err", 32'(err), 32'd0);
      check("t6_alias_lat", 32'(lat), 32'd2);
      check("t6_alias_rdata", rd, 32'hFB020910);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Mem_r and Mem_w must never overlap.
   always @(negedge clk_i) begin
      if (mem_r_o && mem_w_o) begin
         n_assert++;
         n_fail++;
         $error("FAIL bus_exclusive: observed r=%b w=%b, expected not both", mem_r_o, mem_w_o);
      end
   end

endmodule
